// File: rtl/acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_pkg                                                              |
// | Shared requester IDs, arbiter state codes and bus width defaults.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package acc_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  localparam logic REQ_W = 1'b0;
  localparam logic REQ_F = 1'b1;

  // State codes double as the one-hot {f,w} grant vector.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GNT_W = 2'b01;
  localparam logic [1:0] GNT_F = 2'b10;

endpackage
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_tag_fifo                                                         |
// | Outstanding-read tag FIFO: {requester id, address} per issued read.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arb_tag_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int             C_PTR_W    = $clog2(DEPTH);
  localparam logic [C_PTR_W:0] C_FULL_CNT = (C_PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_count == C_FULL_CNT);
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mem_rd_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_rd_arb                                                           |
// | Round-robin, burst-locked read-port arbiter with in-order response   |
// | routing for the weight and feature-map BIUs.                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_rd_arb
  import acc_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int OUTS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_req,
  input  logic          w_vld,
  input  logic [AW-1:0] w_addr,
  output logic          w_rdy,
  output logic          w_rsp_vld,
  output logic [AW-1:0] w_rsp_addr,
  output logic [DW-1:0] w_rsp_data,
  input  logic          w_rsp_rdy,
  input  logic          f_req,
  input  logic          f_vld,
  input  logic [AW-1:0] f_addr,
  output logic          f_rdy,
  output logic          f_rsp_vld,
  output logic [AW-1:0] f_rsp_addr,
  output logic [DW-1:0] f_rsp_data,
  input  logic          f_rsp_rdy,
  output logic          mem_vld,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rdy,
  input  logic          mem_rsp_vld,
  input  logic [DW-1:0] mem_rsp_data,
  output logic          mem_rsp_rdy,
  output logic [1:0]    grant,
  output logic          err
);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_last;
  logic          w_last_nxt;
  logic          r_err;
  logic          w_own_vld;
  logic [AW-1:0] w_own_addr;
  logic          w_own_id;
  logic          w_issue;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_head;
  logic          w_head_id;
  logic          w_tgt_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_req && f_req) w_state_nxt = (r_last == REQ_F) ? GNT_W : GNT_F;
        else if (w_req)     w_state_nxt = GNT_W;
        else if (f_req)     w_state_nxt = GNT_F;
      end
      GNT_W: begin
        if (!w_req) begin
          w_state_nxt = f_req ? GNT_F : IDLE;
          w_last_nxt  = REQ_W;
        end
      end
      GNT_F: begin
        if (!f_req) begin
          w_state_nxt = w_req ? GNT_W : IDLE;
          w_last_nxt  = REQ_F;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= REQ_F;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      if (mem_rsp_vld && w_empty) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_own_vld  = 1'b0;
    w_own_addr = '0;
    w_own_id   = REQ_W;
    case (r_state)
      GNT_W: begin
        w_own_vld  = w_vld;
        w_own_addr = w_addr;
      end
      GNT_F: begin
        w_own_vld  = f_vld;
        w_own_addr = f_addr;
        w_own_id   = REQ_F;
      end
      default: ;
    endcase
  end

  assign mem_vld  = w_own_vld & ~w_full;
  assign mem_addr = w_own_addr;
  assign w_rdy    = (r_state == GNT_W) & mem_rdy & ~w_full;
  assign f_rdy    = (r_state == GNT_F) & mem_rdy & ~w_full;
  assign w_issue  = mem_vld & mem_rdy;

  arb_tag_fifo #(
    .WIDTH (AW + 1),
    .DEPTH (OUTS)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_issue),
    .push_data ({w_own_id, mem_addr}),
    .pop       (mem_rsp_vld & mem_rsp_rdy),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_head_id  = w_head[AW];
  assign w_rsp_vld  = mem_rsp_vld & ~w_empty & (w_head_id == REQ_W);
  assign f_rsp_vld  = mem_rsp_vld & ~w_empty & (w_head_id == REQ_F);
  assign w_rsp_addr = w_head[AW-1:0];
  assign f_rsp_addr = w_head[AW-1:0];
  assign w_rsp_data = mem_rsp_data;
  assign f_rsp_data = mem_rsp_data;
  assign w_tgt_rdy  = (w_head_id == REQ_F) ? f_rsp_rdy : w_rsp_rdy;

  // With no tag outstanding a response has no owner: accept and drop it.
  assign mem_rsp_rdy = w_empty ? mem_rsp_vld : w_tgt_rdy;

  assign grant = r_state;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_rd_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_rd_arb                                                        |
// | Self-checking bench: FSM vector table plus scoreboarded sequences.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_rd_arb;
  import acc_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OUTS = 4;
  localparam int LAT = 3;
  localparam logic [31:0] K = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic rst_n;
  logic w_req, w_vld, w_rdy, w_rsp_vld, w_rsp_rdy;
  logic f_req, f_vld, f_rdy, f_rsp_vld, f_rsp_rdy;
  logic [AW-1:0] w_addr, w_rsp_addr, f_addr, f_rsp_addr, mem_addr;
  logic [DW-1:0] w_rsp_data, f_rsp_data, mem_rsp_data;
  logic mem_vld, mem_rdy, mem_rsp_vld, mem_rsp_rdy, err;
  logic [1:0] grant;

  always #5 clk = ~clk;

  mem_rd_arb #(.AW(AW), .DW(DW), .OUTS(OUTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_req(w_req), .w_vld(w_vld), .w_addr(w_addr), .w_rdy(w_rdy),
    .w_rsp_vld(w_rsp_vld), .w_rsp_addr(w_rsp_addr), .w_rsp_data(w_rsp_data), .w_rsp_rdy(w_rsp_rdy),
    .f_req(f_req), .f_vld(f_vld), .f_addr(f_addr), .f_rdy(f_rdy),
    .f_rsp_vld(f_rsp_vld), .f_rsp_addr(f_rsp_addr), .f_rsp_data(f_rsp_data), .f_rsp_rdy(f_rsp_rdy),
    .mem_vld(mem_vld), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
    .mem_rsp_vld(mem_rsp_vld), .mem_rsp_data(mem_rsp_data), .mem_rsp_rdy(mem_rsp_rdy),
    .grant(grant), .err(err)
  );

  typedef struct { logic id; logic [31:0] addr; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int t; } mreq_t;
  typedef struct { logic wq, fq, wv, fv, mr; logic [1:0] g; logic wr, fr, mv; } vec_t;

  exp_t  sb[$];
  mreq_t mq[$];
  vec_t  tbl[12];

  int checks = 0, errors = 0, cyc = 0;
  int w_left = 0, f_left = 0;
  logic [31:0] w_next = 0, f_next = 0;
  logic n_w_req = 0, n_f_req = 0, n_mem_rdy = 0, n_w_rsp_rdy = 0, n_f_rsp_rdy = 0;
  logic rsp_en = 0, rsp_force = 0;
  int w_iss = 0, f_iss = 0, w_got = 0, f_got = 0, f_seen = 0, hist_n = 0;
  logic [7:0] id_hist = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rsp(input logic id, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_unexpected: id %0d addr %h with empty scoreboard", id, addr);
    end else begin
      e = sb.pop_front();
      chk("rsp_id", 32'(id), 32'(e.id));
      chk("rsp_addr", addr, e.addr);
      chk("rsp_data", data, e.data);
      if (hist_n < 8) id_hist[hist_n] = id;
      hist_n++;
    end
  endtask

  // One clock: drive at negedge, sample handshakes 1 ns later.
  task automatic cycle();
    logic wf, ff, mf, rf, wa, fa;
    @(negedge clk);
    cyc++;
    w_req = n_w_req; f_req = n_f_req; mem_rdy = n_mem_rdy;
    w_rsp_rdy = n_w_rsp_rdy; f_rsp_rdy = n_f_rsp_rdy;
    w_vld = (w_left > 0); w_addr = w_next;
    f_vld = (f_left > 0); f_addr = f_next;
    if (rsp_force) begin
      mem_rsp_vld = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    end else if (rsp_en && mq.size() > 0 && cyc >= mq[0].t) begin
      mem_rsp_vld = 1'b1; mem_rsp_data = mq[0].addr ^ K;
    end else begin
      mem_rsp_vld = 1'b0; mem_rsp_data = '0;
    end
    #1;
    wf = w_vld & w_rdy;  ff = f_vld & f_rdy;
    mf = mem_vld & mem_rdy;  rf = mem_rsp_vld & mem_rsp_rdy;
    wa = w_rsp_vld & w_rsp_rdy;  fa = f_rsp_vld & f_rsp_rdy;
    if (f_rsp_vld) f_seen++;
    if (wf) begin sb.push_back('{REQ_W, w_addr, w_addr ^ K}); w_next += 4; w_left--; w_iss++; end
    if (ff) begin sb.push_back('{REQ_F, f_addr, f_addr ^ K}); f_next += 4; f_left--; f_iss++; end
    if (mf) mq.push_back('{mem_addr, cyc + LAT});
    if (rf && !rsp_force && mq.size() > 0) void'(mq.pop_front());
    if (wa) begin check_rsp(REQ_W, w_rsp_addr, w_rsp_data); w_got++; end
    if (fa) begin check_rsp(REQ_F, f_rsp_addr, f_rsp_data); f_got++; end
  endtask

  task automatic drive_idle();
    w_req = 0; f_req = 0; w_vld = 0; f_vld = 0; w_addr = 0; f_addr = 0;
    w_rsp_rdy = 0; f_rsp_rdy = 0; mem_rdy = 0; mem_rsp_vld = 0; mem_rsp_data = 0;
  endtask

  task automatic clear_model();
    n_w_req = 0; n_f_req = 0; n_mem_rdy = 0; n_w_rsp_rdy = 0; n_f_rsp_rdy = 0;
    w_left = 0; f_left = 0; rsp_en = 0; rsp_force = 0;
    sb.delete(); mq.delete();
    w_iss = 0; f_iss = 0; w_got = 0; f_got = 0; f_seen = 0; hist_n = 0; id_hist = '0;
  endtask

  task automatic do_reset();
    clear_model();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           wq fq wv fv mr  grant  wr fr mv
    tbl[0]  = '{0, 0, 0, 0, 1, 2'b00, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 1, 2'b00, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 1, 2'b01, 1, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 0, 2'b01, 0, 0, 1};
    tbl[4]  = '{0, 1, 1, 1, 0, 2'b10, 0, 0, 1};
    tbl[5]  = '{0, 1, 0, 0, 1, 2'b10, 0, 1, 0};
    tbl[6]  = '{1, 1, 0, 0, 1, 2'b10, 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 1, 2'b10, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 2'b01, 1, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 1, 2'b00, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 2'b10, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 2'b00, 0, 0, 0};

    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_mem_vld", 32'(mem_vld), 0);
    chk("rst_w_rdy", 32'(w_rdy), 0);
    chk("rst_f_rdy", 32'(f_rdy), 0);
    chk("rst_w_rsp_vld", 32'(w_rsp_vld), 0);
    chk("rst_f_rsp_vld", 32'(f_rsp_vld), 0);
    chk("rst_mem_rsp_rdy", 32'(mem_rsp_rdy), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arbitration vectors, applied back to back from reset.
    for (int i = 0; i < 12; i++) begin
      n_w_req = tbl[i].wq; n_f_req = tbl[i].fq; n_mem_rdy = tbl[i].mr;
      w_left = int'(tbl[i].wv); f_left = int'(tbl[i].fv);
      cycle();
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d_w_rdy", i), 32'(w_rdy), 32'(tbl[i].wr));
      chk($sformatf("vec%0d_f_rdy", i), 32'(f_rdy), 32'(tbl[i].fr));
      chk($sformatf("vec%0d_mem_vld", i), 32'(mem_vld), 32'(tbl[i].mv));
    end

    // W only: 72 reads, memory latency 3.
    do_reset();
    w_next = 32'h1000; w_left = 72;
    n_w_req = 1; n_mem_rdy = 1; n_w_rsp_rdy = 1; n_f_rsp_rdy = 1; rsp_en = 1;
    cycle();
    chk("wonly_grant_req_cycle", 32'(grant), 0);
    cycle();
    chk("wonly_grant_next", 32'(grant), 32'(GNT_W));
    for (int i = 0; i < 600 && w_got < 72; i++) cycle();
    chk("wonly_rsp_count", w_got, 72);
    chk("wonly_f_rsp_vld_seen", f_seen, 0);
    chk("wonly_sb_empty", sb.size(), 0);

    // Tie after reset, then handover without an idle cycle.
    do_reset();
    w_next = 32'h3000; f_next = 32'h4000; w_left = 8; f_left = 2;
    n_w_req = 1; n_f_req = 1; n_mem_rdy = 1; n_w_rsp_rdy = 1; n_f_rsp_rdy = 1; rsp_en = 1;
    cycle();
    chk("tie_grant_req_cycle", 32'(grant), 0);
    cycle();
    chk("tie_grant_w_first", 32'(grant), 32'(GNT_W));
    for (int i = 0; i < 100 && w_iss < 8; i++) cycle();
    n_w_req = 0;
    cycle();
    chk("tie_grant_drop_cycle", 32'(grant), 32'(GNT_W));
    cycle();
    chk("tie_grant_handover", 32'(grant), 32'(GNT_F));
    for (int i = 0; i < 100 && (w_got < 8 || f_got < 2); i++) cycle();
    chk("tie_w_count", w_got, 8);
    chk("tie_f_count", f_got, 2);

    // Interleaved drain: W tags still outstanding when F takes over.
    do_reset();
    w_next = 32'h5000; f_next = 32'h6000; w_left = 3; f_left = 2;
    n_w_req = 1; n_f_req = 1; n_mem_rdy = 1; n_w_rsp_rdy = 1; n_f_rsp_rdy = 1;
    for (int i = 0; i < 50 && w_iss < 3; i++) cycle();
    n_w_req = 0;
    for (int i = 0; i < 50 && f_iss < 1; i++) cycle();
    rsp_en = 1;
    for (int i = 0; i < 100 && hist_n < 5; i++) cycle();
    chk("drain_rsp_count", hist_n, 5);
    chk("drain_order", 32'(id_hist[4:0]), 32'b11000);
    n_f_req = 0;

    // Full FIFO: four fires, then blocked until a pop has taken effect.
    do_reset();
    w_next = 32'h7000; w_left = 10;
    n_w_req = 1; n_mem_rdy = 1; n_w_rsp_rdy = 1;
    repeat (8) cycle();
    chk("full_fires", w_iss, 4);
    chk("full_w_rdy", 32'(w_rdy), 0);
    rsp_en = 1;
    cycle();
    rsp_en = 0;
    chk("full_pop_got", w_got, 1);
    chk("full_pop_cycle_w_rdy", 32'(w_rdy), 0);
    chk("full_pop_cycle_fires", w_iss, 4);
    cycle();
    chk("full_after_pop_w_rdy", 32'(w_rdy), 1);
    chk("full_fifth_fire", w_iss, 5);
    w_left = 0; rsp_en = 1;
    for (int i = 0; i < 100 && w_got < 5; i++) cycle();
    chk("full_drain_count", w_got, 5);
    chk("full_sb_empty", sb.size(), 0);

    // Response backpressure.
    do_reset();
    w_next = 32'h2000; w_left = 1;
    n_w_req = 1; n_mem_rdy = 1; n_w_rsp_rdy = 0; rsp_en = 1;
    for (int i = 0; i < 20 && !mem_rsp_vld; i++) cycle();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle();
      chk("bp_mem_rsp_rdy", 32'(mem_rsp_rdy), 0);
      chk("bp_w_rsp_vld", 32'(w_rsp_vld), 1);
      chk("bp_w_rsp_data", w_rsp_data, 32'h2000 ^ K);
    end
    chk("bp_no_accept", w_got, 0);
    n_w_rsp_rdy = 1;
    cycle();
    chk("bp_accept", w_got, 1);
    cycle();
    chk("bp_w_rsp_vld_after", 32'(w_rsp_vld), 0);

    // Stray response with empty FIFO.
    n_w_req = 0;
    rsp_force = 1;
    cycle();
    rsp_force = 0;
    chk("stray_mem_rsp_rdy", 32'(mem_rsp_rdy), 1);
    chk("stray_w_rsp_vld", 32'(w_rsp_vld), 0);
    chk("stray_f_rsp_vld", 32'(f_rsp_vld), 0);
    chk("stray_err_before", 32'(err), 0);
    cycle();
    chk("stray_err_set", 32'(err), 1);

    // Asynchronous reset mid-burst with tags in flight.
    w_next = 32'h8000; w_left = 6; n_w_req = 1; n_mem_rdy = 1; rsp_en = 0;
    repeat (4) cycle();
    chk("midrst_grant_pre", 32'(grant), 32'(GNT_W));
    chk("midrst_err_pre", 32'(err), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 0);
    chk("midrst_mem_vld", 32'(mem_vld), 0);
    chk("midrst_w_rdy", 32'(w_rdy), 0);
    chk("midrst_w_rsp_vld", 32'(w_rsp_vld), 0);
    chk("midrst_mem_rsp_rdy", 32'(mem_rsp_rdy), 0);
    chk("midrst_err", 32'(err), 0);
    clear_model();
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    n_w_rsp_rdy = 1; n_f_rsp_rdy = 1;
    rsp_force = 1;
    cycle();
    rsp_force = 0;
    chk("postrst_w_rsp_vld", 32'(w_rsp_vld), 0);
    chk("postrst_f_rsp_vld", 32'(f_rsp_vld), 0);
    cycle();
    chk("postrst_err", 32'(err), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
